alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single combinational RV32 ALU between two requesters, e.g. the execute stage and the branch/address unit. Each requester presents a full ALU operation over a valid/ready handshake. The block grants one operation at a time, drives the ALU from registered operands, and captures the result and flags. It returns them on the granted requester's response channel. Sits between the requesters and the ALU instance; the ALU has no other driver.

---
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter that time-shares one combinational RV32 ALU; optional ALU_ARB_RR_EN selects round-robin over fixed r0 priority.
// Latency: result valid one cycle after the accept edge; one op in flight, so at least 3 cycles between accepts.
// Backpressure: no request is accepted until the pending response is taken; response data is held until then.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_in1,
    input  logic [31:0] r0_in2,
    input  logic [4:0]  r0_shamt,
    input  logic        r0_use_shamt,
    input  logic [2:0]  r0_funct3,
    input  logic [6:0]  r0_funct7,
    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_in1,
    input  logic [31:0] r1_in2,
    input  logic [4:0]  r1_shamt,
    input  logic        r1_use_shamt,
    input  logic [2:0]  r1_funct3,
    input  logic [6:0]  r1_funct7,
    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,

    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,

    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [4:0]  alu_shamt,
    output logic        alu_use_shamt,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] op_in1_q, op_in2_q;
    logic [4:0]  op_shamt_q;
    logic        op_use_shamt_q;
    logic [2:0]  op_funct3_q;
    logic [6:0]  op_funct7_q;
    logic        gnt_id_q;
    logic [1:0]  rsp_vld_q;
    logic        gnt0, gnt1;
    logic        acc0, acc1;
    logic        rsp_hs;
    logic        op_unsupported;

`ifdef ALU_ARB_RR_EN
    logic last_r1_q;

    always_comb begin
        if (r0_valid && r1_valid) begin
            gnt0 = last_r1_q;
            gnt1 = !last_r1_q;
        end else begin
            gnt0 = r0_valid;
            gnt1 = r1_valid;
        end
    end

    // Reset to "last granted r1" so r0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_r1_q <= 1'b1;
        else if (rsp_hs)
            last_r1_q <= gnt_id_q;
    end
`else
    always_comb begin
        gnt0 = r0_valid;
        gnt1 = r1_valid && !r0_valid;
    end
`endif

    // Gated by rst_n so ready stays low while reset is held, not just after it.
    assign r0_ready = rst_n && (state_q == IDLE) && gnt0;
    assign r1_ready = rst_n && (state_q == IDLE) && gnt1;
    assign acc0     = r0_valid && r0_ready;
    assign acc1     = r1_valid && r1_ready;

    assign rsp_hs = (state_q == RESP) && (gnt_id_q ? r1_rsp_ready : r0_rsp_ready);

    assign op_unsupported = !((op_funct7_q == 7'b0000000) ||
                              ((op_funct7_q == 7'b0100000) &&
                               ((op_funct3_q == 3'b000) || (op_funct3_q == 3'b101))));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc0 || acc1) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_in1_q       <= '0;
            op_in2_q       <= '0;
            op_shamt_q     <= '0;
            op_use_shamt_q <= 1'b0;
            op_funct3_q    <= '0;
            op_funct7_q    <= '0;
            gnt_id_q       <= 1'b0;
        end else if (acc1) begin
            op_in1_q       <= r1_in1;
            op_in2_q       <= r1_in2;
            op_shamt_q     <= r1_shamt;
            op_use_shamt_q <= r1_use_shamt;
            op_funct3_q    <= r1_funct3;
            op_funct7_q    <= r1_funct7;
            gnt_id_q       <= 1'b1;
        end else if (acc0) begin
            op_in1_q       <= r0_in1;
            op_in2_q       <= r0_in2;
            op_shamt_q     <= r0_shamt;
            op_use_shamt_q <= r0_use_shamt;
            op_funct3_q    <= r0_funct3;
            op_funct7_q    <= r0_funct7;
            gnt_id_q       <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            rsp_vld_q <= 2'b00;
        end else if (state_q == EXEC) begin
            if (op_unsupported) begin
                rsp_data  <= '0;
                rsp_flags <= '0;
                rsp_err   <= 1'b1;
            end else begin
                rsp_data  <= alu_out;
                rsp_flags <= {alu_carry, alu_negative, alu_zero, alu_overflow};
                rsp_err   <= 1'b0;
            end
            rsp_vld_q <= gnt_id_q ? 2'b10 : 2'b01;
        end else if (rsp_hs) begin
            rsp_vld_q <= 2'b00;
        end
    end

    assign r0_rsp_valid = rsp_vld_q[0];
    assign r1_rsp_valid = rsp_vld_q[1];

    assign alu_in1       = op_in1_q;
    assign alu_in2       = op_in2_q;
    assign alu_shamt     = op_shamt_q;
    assign alu_use_shamt = op_use_shamt_q;
    assign alu_funct3    = op_funct3_q;
    assign alu_funct7    = op_funct7_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU attached to the alu_* port.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rv, rr, rdy, rsp_v;
    logic [31:0] in1 [2];
    logic [31:0] in2 [2];
    logic [4:0]  sh  [2];
    logic        us  [2];
    logic [2:0]  f3  [2];
    logic [6:0]  f7  [2];
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [4:0]  alu_shamt;
    logic        alu_use_shamt;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic        alu_carry, alu_negative, alu_zero, alu_overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(rv[0]), .r0_ready(rdy[0]), .r0_in1(in1[0]), .r0_in2(in2[0]),
        .r0_shamt(sh[0]), .r0_use_shamt(us[0]), .r0_funct3(f3[0]), .r0_funct7(f7[0]),
        .r0_rsp_valid(rsp_v[0]), .r0_rsp_ready(rr[0]),
        .r1_valid(rv[1]), .r1_ready(rdy[1]), .r1_in1(in1[1]), .r1_in2(in2[1]),
        .r1_shamt(sh[1]), .r1_use_shamt(us[1]), .r1_funct3(f3[1]), .r1_funct7(f7[1]),
        .r1_rsp_valid(rsp_v[1]), .r1_rsp_ready(rr[1]),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt),
        .alu_use_shamt(alu_use_shamt), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_negative(alu_negative),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow)
    );

    // Reference ALU: flags are {carry, negative, zero, overflow}; carry/overflow only for add/sub.
    logic [31:0] bop;
    logic [32:0] sum;
    logic [4:0]  samt;
    logic        sub;
    always_comb begin
        sub          = (alu_funct3 == 3'b000) && alu_funct7[5];
        bop          = sub ? ~alu_in2 : alu_in2;
        sum          = {1'b0, alu_in1} + {1'b0, bop} + {32'd0, sub};
        samt         = alu_use_shamt ? alu_shamt : alu_in2[4:0];
        alu_out      = 32'd0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_funct3)
            3'b000: begin
                alu_out      = sum[31:0];
                alu_carry    = sum[32];
                alu_overflow = (alu_in1[31] == bop[31]) && (sum[31] != alu_in1[31]);
            end
            3'b001: alu_out = alu_in1 << samt;
            3'b100: alu_out = alu_in1 ^ alu_in2;
            3'b101: begin
                if (alu_funct7[5]) alu_out = $unsigned($signed(alu_in1) >>> samt);
                else               alu_out = alu_in1 >> samt;
            end
            3'b110: alu_out = alu_in1 | alu_in2;
            3'b111: alu_out = alu_in1 & alu_in2;
            default: alu_out = 32'd0;
        endcase
        alu_negative = alu_out[31];
        alu_zero     = (alu_out == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on port p, response held off for 'stall' cycles.
    task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input logic u, input logic [2:0] fn3,
                         input logic [6:0] fn7, input logic [31:0] ed, input logic [3:0] ef,
                         input logic ee, input int stall);
        int q;
        logic [1:0] ev;
        q  = 1 - p;
        ev = (p == 0) ? 2'b01 : 2'b10;
        @(posedge clk); #1;
        in1[p] = a; in2[p] = b; sh[p] = s; us[p] = u; f3[p] = fn3; f7[p] = fn7;
        rv[p]  = 1'b1;
        #4;
        chk("acc_ready", 32'(rdy[p]), 32'd1);
        chk("acc_ready_other", 32'(rdy[q]), 32'd0);
        @(posedge clk); #1;
        rv[p] = 1'b0;
        #4;
        chk("exec_alu_in1", alu_in1, a);
        chk("exec_alu_in2", alu_in2, b);
        chk("exec_alu_ctl", 32'({alu_use_shamt, alu_shamt, alu_funct7, alu_funct3}), 32'({u, s, fn7, fn3}));
        chk("exec_rsp_valid", 32'(rsp_v), 32'd0);
        for (int i = 0; i <= stall; i++) begin
            @(posedge clk); #1;
            if (i < stall) rv = 2'b11;
            else begin rv = 2'b00; rr[p] = 1'b1; end
            #4;
            chk("rsp_valid", 32'(rsp_v), 32'(ev));
            chk("rsp_data", rsp_data, ed);
            chk("rsp_flags", 32'(rsp_flags), 32'(ef));
            chk("rsp_err", 32'(rsp_err), 32'(ee));
            chk("rsp_ready_low", 32'(rdy), 32'd0);
        end
        @(posedge clk); #1;
        rr = 2'b00;
        #4;
        chk("idle_rsp_valid", 32'(rsp_v), 32'd0);
        chk("idle_alu_hold", alu_in1, a);
    endtask

    initial begin
        logic [1:0]  eg;
        logic [31:0] ed;
        rst_n = 1'b0;
        rv = 2'b11; rr = 2'b00;
        for (int k = 0; k < 2; k++) begin
            in1[k] = 32'd0; in2[k] = 32'd0; sh[k] = 5'd0; us[k] = 1'b0; f3[k] = 3'd0; f7[k] = 7'd0;
        end
        #1;
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_v), 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_flags_err", 32'({rsp_flags, rsp_err}), 32'd0);
        rv = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(0, 32'hFFFF_FFFF, 32'd1,   5'd0, 1'b0, 3'b000, 7'h00, 32'h0000_0000, 4'b1010, 1'b0, 0);
        do_op(1, 32'h8000_0000, 32'd8,   5'd4, 1'b1, 3'b101, 7'h20, 32'hF800_0000, 4'b0100, 1'b0, 0);
        do_op(0, 32'd5,         32'd7,   5'd0, 1'b0, 3'b000, 7'h20, 32'hFFFF_FFFE, 4'b0100, 1'b0, 5);
        do_op(1, 32'hF000_0000, 32'h24,  5'd9, 1'b0, 3'b101, 7'h00, 32'h0F00_0000, 4'b0000, 1'b0, 0);
        do_op(0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 1'b0, 3'b111, 7'h00, 32'h0F00_0F00, 4'b0000, 1'b0, 0);
        do_op(1, 32'h8000_0000, 32'd0,   5'd0, 1'b0, 3'b100, 7'h20, 32'h0000_0000, 4'b0000, 1'b1, 0);
        do_op(0, 32'd3,         32'd4,   5'd0, 1'b0, 3'b000, 7'h01, 32'h0000_0000, 4'b0000, 1'b1, 0);

        // Abort an op while it is in EXEC.
        @(posedge clk); #1;
        in1[0] = 32'd1;  in2[0] = 32'd2;  sh[0] = 5'd0; us[0] = 1'b0; f3[0] = 3'b000; f7[0] = 7'h00;
        in1[1] = 32'd10; in2[1] = 32'd20; sh[1] = 5'd0; us[1] = 1'b0; f3[1] = 3'b000; f7[1] = 7'h00;
        rv = 2'b01;
        @(posedge clk); #1;
        rv = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(rdy), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_v), 32'd0);
        chk("abort_alu_in1", alu_in1, 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        @(posedge clk); #1;
        chk("abort_no_rsp", 32'(rsp_v), 32'd0);
        rst_n = 1'b1;
        rr = 2'b11;
        #3;

        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            eg = 2'b01;
`endif
            ed = (eg == 2'b01) ? 32'd3 : 32'd30;
            chk("tie_grant", 32'(rdy), 32'(eg));
            @(posedge clk); #1;
            @(posedge clk); #3;
            chk("tie_rsp_valid", 32'(rsp_v), 32'(eg));
            chk("tie_rsp_data", rsp_data, ed);
            @(posedge clk); #3;
        end
        rv = 2'b00;
        rr = 2'b00;
        @(posedge clk); #4;
        chk("final_idle", 32'({rdy, rsp_v}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
